// File: rtl/mod_sequencer.sv
// Mode/timing controller for the ASK/FSK/PSK modulation datapath: key debounce,
// symbol-aligned mode commits, PN bit latching and dual-port sine ROM addressing.
module mod_sequencer #(
  parameter int unsigned AW      = 8,
  parameter int unsigned SYM_LEN = 256,
  parameter int unsigned DEB_CYC = 1024,
  parameter int unsigned F0_STEP = 1,
  parameter int unsigned F1_STEP = 2,
  parameter int unsigned PSK_OFS = 128
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [2:0]    key,
  input  logic          m,
  output logic [AW-1:0] addr_mod,
  output logic [AW-1:0] addr_ref,
  output logic [1:0]    mode,
  output logic          bit_q,
  output logic          sym_stb,
  output logic          mode_chg
);

  localparam int unsigned SW = (SYM_LEN > 1) ? $clog2(SYM_LEN) : 1;
  localparam int unsigned DW = $clog2(DEB_CYC + 1);

  localparam logic [SW-1:0] SYM_LAST = SW'(SYM_LEN - 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);
  localparam logic [DW-1:0] DEB_SAT  = DW'(DEB_CYC);
  localparam logic [AW-1:0] ONE      = AW'(1);
  localparam logic [AW-1:0] F0_V     = AW'(F0_STEP);
  localparam logic [AW-1:0] F1_V     = AW'(F1_STEP);
  localparam logic [AW-1:0] PSK_V    = AW'(PSK_OFS);

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t          state;
  logic [2:0]      key_s1, key_s2, key_prev;
  logic [DW-1:0]   deb_cnt;
  logic            m_s1, m_s2;
  logic [SW-1:0]   sym_cnt;
  logic [1:0]      req_mode;
  logic            req_vld;
  logic [1:0]      req_code;
  logic [AW-1:0]   ref_nxt, mod_nxt;

  assign sym_stb  = (sym_cnt == SYM_LAST);
  assign mode_chg = (state == PEND) && sym_stb;

  // Synchronizers reset to "released" so reset never looks like a CW press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_s1   <= '1;
      key_s2   <= '1;
      key_prev <= '1;
      deb_cnt  <= '0;
      m_s1     <= 1'b0;
      m_s2     <= 1'b0;
    end else begin
      key_s1   <= key;
      key_s2   <= key_s1;
      key_prev <= key_s2;
      m_s1     <= m;
      m_s2     <= m_s1;
      if (key_s2 != key_prev)
        deb_cnt <= '0;
      else if (deb_cnt != DEB_SAT)
        deb_cnt <= deb_cnt + DW'(1);
    end
  end

  // Saturating counter: the decode fires exactly once per stable pattern.
  always_comb begin
    req_vld  = 1'b0;
    req_code = 2'd0;
    if ((key_s2 == key_prev) && (deb_cnt == DEB_LAST)) begin
      case (key_prev)
        3'b110:  begin req_vld = 1'b1; req_code = 2'd1; end
        3'b101:  begin req_vld = 1'b1; req_code = 2'd2; end
        3'b011:  begin req_vld = 1'b1; req_code = 2'd3; end
        3'b000:  begin req_vld = 1'b1; req_code = 2'd0; end
        default: begin req_vld = 1'b0; req_code = 2'd0; end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym_cnt  <= '0;
      bit_q    <= 1'b0;
      state    <= RUN;
      mode     <= 2'd0;
      req_mode <= 2'd0;
    end else begin
      sym_cnt <= sym_stb ? '0 : sym_cnt + SW'(1);
      if (sym_stb)
        bit_q <= m_s2;
      if (mode_chg) begin
        mode <= req_mode;
        // A request landing on the commit cycle is queued for the next boundary.
        if (req_vld && (req_code != req_mode)) begin
          state    <= PEND;
          req_mode <= req_code;
        end else begin
          state <= RUN;
        end
      end else if (req_vld) begin
        if (state == PEND) begin
          req_mode <= req_code;
        end else if (req_code != mode) begin
          state    <= PEND;
          req_mode <= req_code;
        end
      end
    end
  end

  always_comb begin
    ref_nxt = addr_ref + ONE;
    case (mode)
      2'd0:    mod_nxt = addr_mod + F0_V;
      2'd1:    mod_nxt = bit_q ? addr_mod + ONE : '0;
      2'd2:    mod_nxt = addr_mod + (bit_q ? F1_V : F0_V);
      default: mod_nxt = bit_q ? ref_nxt : ref_nxt + PSK_V;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_ref <= '0;
      addr_mod <= '0;
    end else if (mode_chg) begin
      addr_ref <= '0;
      addr_mod <= '0;
    end else begin
      addr_ref <= ref_nxt;
      addr_mod <= mod_nxt;
    end
  end

endmodule

// File: tb/tb_mod_sequencer.sv
// Directed scenarios with random PN data, checked every cycle against a
// cycle-indexed behavioural model of the sequencer.
module tb_mod_sequencer;

  localparam int unsigned S = 128;
  localparam int unsigned D = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] key = 3'b111;
  logic       m = 1'b0;
  logic [7:0] addr_mod, addr_ref;
  logic [1:0] mode;
  logic       bit_q, sym_stb, mode_chg;

  mod_sequencer #(
    .AW(8), .SYM_LEN(S), .DEB_CYC(D), .F0_STEP(1), .F1_STEP(2), .PSK_OFS(128)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key(key), .m(m),
    .addr_mod(addr_mod), .addr_ref(addr_ref), .mode(mode),
    .bit_q(bit_q), .sym_stb(sym_stb), .mode_chg(mode_chg)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned at;
    logic [2:0]  pat;
  } fire_t;

  fire_t       fq[$];
  int unsigned cyc;
  int unsigned e_mode, e_req;
  logic        e_bit, e_pend, md1, md2;
  logic [7:0]  e_am, e_ar;
  int unsigned m_mode;
  int unsigned n_tests, n_fail;
  int unsigned chg_cnt;
  logic        saw2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void decode(input logic [2:0] p, output logic v, output int unsigned c);
    v = 1'b1;
    case (p)
      3'b110:  c = 1;
      3'b101:  c = 2;
      3'b011:  c = 3;
      3'b000:  c = 0;
      default: begin v = 1'b0; c = 0; end
    endcase
  endfunction

  function automatic void model_reset();
    cyc = 0; e_mode = 0; e_req = 0; e_bit = 1'b0; e_pend = 1'b0;
    md1 = 1'b0; md2 = 1'b0; e_am = '0; e_ar = '0;
    fq.delete();
  endfunction

  // Advance the model across the clock edge that ends cycle cyc+1.
  task automatic model_edge();
    logic        stb, rv;
    int unsigned rc;
    logic [7:0]  arn;
    stb = ((cyc + 1) % S == 0);
    cyc++;
    rv = 1'b0;
    rc = 0;
    while (fq.size() > 0 && fq[0].at < cyc) void'(fq.pop_front());
    if (fq.size() > 0 && fq[0].at == cyc) begin
      decode(fq[0].pat, rv, rc);
      void'(fq.pop_front());
    end
    arn = 8'(e_ar + 1);
    case (e_mode)
      0:       e_am = 8'(e_am + 1);
      1:       e_am = e_bit ? 8'(e_am + 1) : 8'd0;
      2:       e_am = 8'(e_am + (e_bit ? 2 : 1));
      default: e_am = 8'(arn + (e_bit ? 0 : 128));
    endcase
    e_ar = arn;
    if (stb && e_pend) begin
      e_mode = e_req;
      e_am = '0;
      e_ar = '0;
      if (rv && rc != e_req) begin e_pend = 1'b1; e_req = rc; end
      else e_pend = 1'b0;
    end else if (rv) begin
      if (e_pend) e_req = rc;
      else if (rc != e_mode) begin e_pend = 1'b1; e_req = rc; end
    end
    if (stb) e_bit = md2;
    md2 = md1;
    md1 = m;
  endtask

  task automatic step(input logic [2:0] k);
    logic        e_stb;
    int unsigned t;
    e_stb = ((cyc + 1) % S == 0);
    chk("addr_ref", 32'(addr_ref), 32'(e_ar));
    chk("addr_mod", 32'(addr_mod), 32'(e_am));
    chk("mode",     32'(mode),     e_mode);
    chk("bit_q",    32'(bit_q),    32'(e_bit));
    chk("sym_stb",  32'(sym_stb),  32'(e_stb));
    chk("mode_chg", 32'(mode_chg), 32'(e_pend && e_stb));
    if (mode_chg === 1'b1) chg_cnt++;
    if (mode === 2'd2) saw2 = 1'b1;
    if (k !== key) begin
      t = cyc + 1;
      while (fq.size() > 0 && fq[$].at > t + 1) void'(fq.pop_back());
      fq.push_back('{at: t + D + 2, pat: k});
      key = k;
    end
    if (cyc % S == S / 2)
      m = (m_mode == 0) ? 1'($urandom_range(0, 1)) : (m_mode == 1);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic run(input int unsigned n, input logic [2:0] k);
    for (int unsigned i = 0; i < n; i++) step(k);
  endtask

  task automatic wait_cnt(input int unsigned x);
    for (int unsigned i = 0; i < S && (cyc % S) != x; i++) step(key);
  endtask

  task automatic press(input logic [2:0] k, input int unsigned hold, input int unsigned after);
    run(hold, k);
    run(after, 3'b111);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_addr_mod", 32'(addr_mod), 0);
    chk("rst_addr_ref", 32'(addr_ref), 0);
    chk("rst_mode",     32'(mode),     0);
    chk("rst_bit_q",    32'(bit_q),    0);
    chk("rst_sym_stb",  32'(sym_stb),  0);
    chk("rst_mode_chg", 32'(mode_chg), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    n_tests = 0; n_fail = 0; chg_cnt = 0; saw2 = 1'b0; m_mode = 0;
    model_reset();
    @(negedge clk);
    chk("init_addr_ref", 32'(addr_ref), 0);
    chk("init_mode", 32'(mode), 0);
    rst_n = 1'b1;
    run(40, 3'b111);

    // T1: asynchronous reset mid-run, then restart from zero
    do_reset();
    run(20, 3'b111);

    // T2: bouncing ASK key, then held -> a single commit to ASK
    chg_cnt = 0;
    for (int unsigned i = 0; i < 50; i++) run(10, (i % 2 == 1) ? 3'b111 : 3'b110);
    press(3'b110, 200, 150);
    chk("t2_chg_count", chg_cnt, 1);
    chk("t2_mode", 32'(mode), 1);

    // T5: ASK with bit 0, then bit 1
    m_mode = 2; run(2 * S, 3'b111);
    m_mode = 1; run(2 * S, 3'b111);

    // T3: FSK with bit 1 (wraps at 256), then bit 0
    press(3'b101, 100, 2 * S);
    chk("t3_mode", 32'(mode), 2);
    m_mode = 2; run(2 * S, 3'b111);

    // T4: PSK with bit 0, bit 1, then random data
    press(3'b011, 100, S);
    chk("t4_mode", 32'(mode), 3);
    m_mode = 2; run(2 * S, 3'b111);
    m_mode = 1; run(2 * S, 3'b111);
    m_mode = 0; run(2 * S, 3'b111);

    // back to CW before the pending-request scenario
    press(3'b000, 100, S + 40);
    chk("cw_mode", 32'(mode), 0);

    // T6: FSK then PSK inside one symbol -> single commit straight to PSK
    wait_cnt(110);
    chg_cnt = 0;
    saw2 = 1'b0;
    run(72, 3'b101);
    press(3'b011, 80, S);
    chk("t6_chg_count", chg_cnt, 1);
    chk("t6_no_fsk", 32'(saw2), 0);
    chk("t6_mode", 32'(mode), 3);

    // T6b: ASK request lands on the boundary cycle -> deferred one symbol
    wait_cnt(61);
    chg_cnt = 0;
    run(100, 3'b110);
    chk("t6b_defer_mode", 32'(mode), 3);
    chk("t6b_defer_chg", chg_cnt, 0);
    run(150, 3'b111);
    chk("t6b_mode", 32'(mode), 1);
    chk("t6b_chg_count", chg_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
